conv_phase_sequencer: RTL

- Cycle-accurate scheduler that generates the `state_end` pulses driving the ConvUnit phase state machine. That state machine sequences INIT=3'b000, A=3'b001, B=3'b010, C=3'b011, then C returns to A.
- Times each phase from configured cycle counts. Counts compute phases (A/B/C) per job.
- Supports a start/done job handshake and upstream stall.
- Tracks the expected phase and flags any mismatch against the state machine's `current_state`.

---
 rtl/conv_phase_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/conv_phase_sequencer.sv
// Phase scheduler for the ConvUnit state machine: times INIT/A/B/C phases from
// latched cycle counts, emits state_end pulses and cross-checks the fed-back state.
module conv_phase_sequencer #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned TILE_W = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_init_len,
  input  logic [CNT_W-1:0]  cfg_phase_len,
  input  logic [TILE_W-1:0] cfg_num_tiles,
  input  logic              stall,
  input  logic [2:0]        current_state,
  output logic              state_end,
  output logic              busy,
  output logic              done,
  output logic [TILE_W-1:0] tile_idx,
  output logic [2:0]        exp_state,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } ctrl_t;

  ctrl_t             r_state;
  ctrl_t             w_state_nxt;

  logic [CNT_W-1:0]  r_init_len;
  logic [CNT_W-1:0]  r_phase_len;
  logic [TILE_W-1:0] r_num_tiles;
  logic              r_init_done;
  logic [CNT_W-1:0]  r_cnt;
  logic [TILE_W-1:0] r_tile;
  logic [2:0]        r_exp;
  logic              r_busy;
  logic              r_err;

  logic [CNT_W-1:0]  w_len_m1;
  logic [TILE_W-1:0] w_tile_inc;
  logic              w_state_end;
  logic              w_last_phase;
  logic              w_check;
  logic [2:0]        w_exp_nxt;

  // Until the INIT phase has completed, the running phase is INIT.
  assign w_len_m1    = (r_init_done ? r_phase_len : r_init_len) - CNT_W'(1);
  assign w_tile_inc  = r_tile + TILE_W'(1);
  assign w_state_end = (r_state == ST_RUN) & ~stall & (r_cnt == w_len_m1);
  assign w_last_phase = r_init_done ? (w_tile_inc == r_num_tiles)
                                    : (r_num_tiles == '0);
  assign w_check     = r_busy | r_init_done;

  always_comb begin
    w_exp_nxt = 3'b001;
    case (r_exp)
      3'b000:  w_exp_nxt = 3'b001;
      3'b001:  w_exp_nxt = 3'b010;
      3'b010:  w_exp_nxt = 3'b011;
      3'b011:  w_exp_nxt = 3'b001;
      default: w_exp_nxt = 3'b001;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (!r_init_done || (cfg_num_tiles != '0)) w_state_nxt = ST_RUN;
          else                                       w_state_nxt = ST_FIN;
        end
      end
      ST_RUN: begin
        if (w_state_end && w_last_phase) w_state_nxt = ST_FIN;
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_init_len  <= '0;
      r_phase_len <= '0;
      r_num_tiles <= '0;
      r_init_done <= 1'b0;
      r_cnt       <= '0;
      r_tile      <= '0;
      r_exp       <= 3'b000;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= r_err | (w_check & (current_state != r_exp));
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_init_len  <= (cfg_init_len  == '0) ? CNT_W'(1) : cfg_init_len;
            r_phase_len <= (cfg_phase_len == '0) ? CNT_W'(1) : cfg_phase_len;
            r_num_tiles <= cfg_num_tiles;
            r_cnt       <= '0;
            r_tile      <= '0;
            r_busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_state_end) begin
            r_cnt <= '0;
            r_exp <= w_exp_nxt;
            if (r_init_done) r_tile      <= w_tile_inc;
            else             r_init_done <= 1'b1;
            if (w_last_phase) r_busy <= 1'b0;
          end else if (!stall) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_FIN:  r_busy <= 1'b0;
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign state_end = w_state_end;
  assign busy      = r_busy;
  assign done      = (r_state == ST_FIN);
  assign tile_idx  = r_tile;
  assign exp_state = r_exp;
  assign err       = r_err;

endmodule
